seg_scan_ctrl: RTL
==================

// Module: seg_scan_ctrl
// PURPOSE
// Parametrised multiplexed 7-segment display driver for NUM_DIG digits. It
// time-multiplexes per-digit hex/BCD nibbles onto a shared segment bus. It adds
// a programmable scan rate, an anti-ghost guard interval, per-digit decimal-point
// and blank masks, and leading-zero suppression. New display data is
// double-buffered and applied only at a frame boundary. Sits between the
// timing/counter logic (e.g. traffic-light countdowns) and the board display pins.
// PARAMETERS
// NUM_DIG      8      number of digits scanned (2..16)
// SCAN_DIV     50000  clocks per digit slot; must be >= 2
// GUARD        2      clocks at slot start with sel deasserted; 0 <= GUARD < SCAN_DIV
// SEG_ACT_LOW  1      1: segment/dp outputs active-low; 0: active-high
// SEL_ACT_LOW  0      1: digit selects active-low; 0: active-high one-hot
// HEX_EN       1      1: decode nibbles A-F; 0: values 10-15 display blank
// PORTS
// clk         in   1          system clock
// rst         in   1          asynchronous reset, active-high
// dat         in   4*NUM_DIG  digit nibbles; digit i = dat[4i+3:4i]; digit 0 = rightmost
// dp          in   NUM_DIG    decimal point enable per digit (1 = lit)
// blank       in   NUM_DIG    force digit blank (1 = blank; dp still honoured)
// lzs         in   1          leading-zero suppression enable (captured with load)
// load        in   1          capture dat/dp/blank/lzs into the pending buffer
// pending     out  1          pending buffer holds data not yet displayed
// seg_out     out  8          {dp,g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
// sel         out  NUM_DIG    digit select, one-hot, polarity per SEL_ACT_LOW
// frame_done  out  1          1-cycle pulse at each frame boundary
// BEHAVIOUR
// - Reset (async, immediate, also mid-slot): prescaler=0, idx=0, pending=0,
//   frame_done=0. Pending buffer cleared. Display regs: dat=0, dp=0, blank=all-1, lzs=0.
//   Outputs at reset: seg_out all off (8'hFF if SEG_ACT_LOW, else 8'h00); sel all off.
// - Prescaler counts 0..SCAN_DIV-1. Terminal count = tick. On the tick edge idx
//   advances NUM_DIG-1 -> 0 (wrap); the prescaler restarts at 0.
// - All outputs are registered. sel is off while prescaler < GUARD, and on for
//   digit idx otherwise. seg_out shows the pattern for idx throughout the slot
//   (from the edge where the prescaler is 0). Active sel per slot = SCAN_DIV-GUARD clocks.
// - Frame boundary = tick while idx==NUM_DIG-1. On that edge frame_done pulses.
//   If pending=1, the display regs load from the pending buffer and pending clears.
//   New data first appears in slot idx 0 of the next frame.
// - load=1 on any edge: pending buffer <= inputs, pending <= 1. A later load
//   before the boundary overwrites the buffer (last wins).
// - load on the boundary edge: the display takes the OLD buffer contents (if
//   pending). The new inputs go to the buffer and pending stays 1.
// - Decode (active-high {dp..a}): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F
//   9=6F A=77 b=7C C=39 d=5E E=79 F=71. HEX_EN=0: 10-15 -> 00.
//   dp sets bit7. Blank clears bits 6:0. SEG_ACT_LOW inverts all 8 bits.
// - lzs=1: scanning from digit NUM_DIG-1 downward, zero digits are blanked
//   until the first nonzero digit. Digit 0 is never suppressed. dp is unaffected.
// - Widths: idx is clog2(NUM_DIG); the prescaler is clog2(SCAN_DIV) bits. No other arithmetic.
// TESTING
// T1 reset: rst=1 mid-slot -> same cycle seg_out=8'hFF, sel=0, pending=0; after release, no load -> all digits 8'hFF.
// T2 NUM_DIG=4,SCAN_DIV=4,GUARD=1: load dat=16'h4321 -> next frame sel 0001,0010,0100,1000,
//    each with 3 active cycles after 1 guard cycle; seg_out F9,A4,B0,99.
// T3 double buffer: load mid-frame -> pending=1, seg_out unchanged until frame_done; then pending=0, new digits shown.
// T4 lzs=1, dat=16'h0050 -> digits 3,2 = FF, digit1 = 92, digit0 = C0; dat=16'h0000 -> only digit0 = C0.
// T5 nibble A: HEX_EN=1 -> 88; with dp=1 -> 08; HEX_EN=0 -> FF. blank bit set with dp=1 -> 7F.
// T6 load on the boundary edge with pending=1 -> display gets the old buffer, pending stays 1, new data shown one frame later.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Display data / scan-output bundle between a display client and seg_scan_ctrl.
// Latency: none (wires only); the client drives the data side, the driver drives the pins.
// Backpressure: none; load is a fire-and-forget strobe and pending reports buffer occupancy.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIG = 8
);
  logic [4*NUM_DIG-1:0] dat;
  logic [NUM_DIG-1:0]   dp;
  logic [NUM_DIG-1:0]   blank;
  logic                 lzs;
  logic                 load;
  logic                 pending;
  logic [7:0]           seg_out;
  logic [NUM_DIG-1:0]   sel;
  logic                 frame_done;

  modport master (
    output dat, dp, blank, lzs, load,
    input  pending, seg_out, sel, frame_done
  );

  modport slave (
    input  dat, dp, blank, lzs, load,
    output pending, seg_out, sel, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment driver: scans NUM_DIG digits with guard interval, dp/blank masks, LZS, double-buffered data.
// Latency: outputs registered; loaded data reaches the pins in slot 0 after the next frame boundary.
// Backpressure: none; a load always lands in the pending buffer (last load before the boundary wins).
module seg_scan_ctrl #(
  parameter int NUM_DIG     = 8,
  parameter int SCAN_DIV    = 50000,
  parameter int GUARD       = 2,
  parameter int SEG_ACT_LOW = 1,
  parameter int SEL_ACT_LOW = 0,
  parameter int HEX_EN      = 1
) (
  input logic            clk,
  input logic            rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int                 IDX_W    = $clog2(NUM_DIG);
  localparam int                 PS_W     = $clog2(SCAN_DIV);
  localparam logic [PS_W-1:0]    PS_LAST  = PS_W'(SCAN_DIV - 1);
  localparam logic [PS_W-1:0]    PS_GUARD = PS_W'(GUARD);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_DIG - 1);
  // XOR masks: convert active-high patterns to pin polarity; also the "all off" value.
  localparam logic [7:0]         SEG_OFF  = {8{(SEG_ACT_LOW != 0)}};
  localparam logic [NUM_DIG-1:0] SEL_OFF  = {NUM_DIG{(SEL_ACT_LOW != 0)}};

  logic [PS_W-1:0]      r_ps;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_pend;
  logic [4*NUM_DIG-1:0] r_pb_dat, r_dd_dat;
  logic [NUM_DIG-1:0]   r_pb_dp, r_pb_blank, r_dd_dp, r_dd_blank;
  logic                 r_pb_lzs, r_dd_lzs;
  logic [7:0]           r_seg;
  logic [NUM_DIG-1:0]   r_sel;
  logic                 r_fd;

  logic                 w_tick, w_boundary, w_apply;
  logic [PS_W-1:0]      w_ps_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [4*NUM_DIG-1:0] w_nd_dat;
  logic [NUM_DIG-1:0]   w_nd_dp, w_nd_blank, w_lz, w_onehot;
  logic                 w_nd_lzs, w_zrun;
  logic [3:0]           w_nib;
  logic [7:0]           w_pat;

  function automatic logic [6:0] f_dec(input logic [3:0] n);
    logic [6:0] c;
    c = 7'h00;
    case (n)
      4'h0: c = 7'h3F;  4'h1: c = 7'h06;  4'h2: c = 7'h5B;  4'h3: c = 7'h4F;
      4'h4: c = 7'h66;  4'h5: c = 7'h6D;  4'h6: c = 7'h7D;  4'h7: c = 7'h07;
      4'h8: c = 7'h7F;  4'h9: c = 7'h6F;  4'hA: c = 7'h77;  4'hB: c = 7'h7C;
      4'hC: c = 7'h39;  4'hD: c = 7'h5E;  4'hE: c = 7'h79;  4'hF: c = 7'h71;
    endcase
    if (HEX_EN == 0 && n > 4'd9) c = 7'h00;
    return c;
  endfunction

  // Scan position after this edge, and the display contents in force after it.
  always_comb begin
    w_tick     = (r_ps == PS_LAST);
    w_boundary = w_tick && (r_idx == IDX_LAST);
    w_apply    = w_boundary && r_pend;
    w_ps_nxt   = w_tick ? '0 : r_ps + PS_W'(1);
    w_idx_nxt  = r_idx;
    if (w_tick) w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    w_nd_dat   = w_apply ? r_pb_dat   : r_dd_dat;
    w_nd_dp    = w_apply ? r_pb_dp    : r_dd_dp;
    w_nd_blank = w_apply ? r_pb_blank : r_dd_blank;
    w_nd_lzs   = w_apply ? r_pb_lzs   : r_dd_lzs;
  end

  // Leading-zero mask: walk down from the top digit while all digits seen are zero; digit 0 always shown.
  always_comb begin
    w_zrun = 1'b1;
    w_lz   = '0;
    for (int j = NUM_DIG - 1; j >= 0; j--) begin
      w_zrun = w_zrun && (w_nd_dat[4*j +: 4] == 4'd0);
      if (j != 0) w_lz[j] = w_nd_lzs && w_zrun;
    end
  end

  // Active-high segment pattern and select for the digit that owns the next slot.
  always_comb begin
    w_nib    = w_nd_dat[{w_idx_nxt, 2'b00} +: 4];
    w_pat    = {w_nd_dp[w_idx_nxt],
                (w_nd_blank[w_idx_nxt] || w_lz[w_idx_nxt]) ? 7'h00 : f_dec(w_nib)};
    w_onehot = '0;
    if (w_ps_nxt >= PS_GUARD) w_onehot[w_idx_nxt] = 1'b1;
  end

  // Prescaler and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ps  <= '0;
      r_idx <= '0;
    end else begin
      r_ps  <= w_ps_nxt;
      r_idx <= w_idx_nxt;
    end
  end

  // Pending buffer and display registers; boundary uses the old buffer even if a load coincides.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_pb_dat   <= '0;
      r_pb_dp    <= '0;
      r_pb_blank <= '0;
      r_pb_lzs   <= 1'b0;
      r_dd_dat   <= '0;
      r_dd_dp    <= '0;
      r_dd_blank <= '1;
      r_dd_lzs   <= 1'b0;
    end else begin
      r_dd_dat   <= w_nd_dat;
      r_dd_dp    <= w_nd_dp;
      r_dd_blank <= w_nd_blank;
      r_dd_lzs   <= w_nd_lzs;
      if (bus.load) begin
        r_pb_dat   <= bus.dat;
        r_pb_dp    <= bus.dp;
        r_pb_blank <= bus.blank;
        r_pb_lzs   <= bus.lzs;
        r_pend     <= 1'b1;
      end else if (w_boundary) begin
        r_pend     <= 1'b0;
      end
    end
  end

  // Registered pin drive in board polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= SEG_OFF;
      r_sel <= SEL_OFF;
      r_fd  <= 1'b0;
    end else begin
      r_seg <= w_pat ^ SEG_OFF;
      r_sel <= w_onehot ^ SEL_OFF;
      r_fd  <= w_boundary;
    end
  end

  assign bus.pending    = r_pend;
  assign bus.seg_out    = r_seg;
  assign bus.sel        = r_sel;
  assign bus.frame_done = r_fd;

endmodule
